mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width.
REQ-002 SHALL have parameter ADDR_BITS, default 10: word address width.
REQ-003 SHALL have parameter MEM_LAT, default 2, legal range >=1: cycles from mem_en sampled to mem_rdata valid.
REQ-004 SHALL have parameter STARVE_MAX, default 4, legal range >=1: consecutive data grants with fetch pending before fetch is forced.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_BITS  fetch address
- if_rdata  out  XLEN  fetch data, registered
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ready
- d_we  in  1  data write enable
- d_addr  in  ADDR_BITS  data address
- d_wdata  in  XLEN  store data
- d_rdata  out  XLEN  load data, registered
- d_ready  out  1  one-cycle data completion pulse
- mem_en, mem_we  out  1 each  memory strobe and write enable, registered
- mem_addr  out  ADDR_BITS  memory address, registered
- mem_wdata  out  XLEN  memory write data, registered
- mem_rdata  in  XLEN  memory read data
- busy  out  1  high whenever state != IDLE

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one access in flight.
REQ-008 In IDLE with any request pending, SHALL select an owner, latch its address/we/wdata, and enter ISSUE next cycle; with none pending, SHALL stay in IDLE.
REQ-009 Selection: d_req wins, except fetch wins when if_req=1 and starve_cnt==STARVE_MAX.
REQ-010 starve_cnt SHALL increment (saturating at STARVE_MAX) on each data grant while if_req=1, clear on fetch grant, and clear in any cycle with if_req=0.
REQ-011 In ISSUE, mem_en SHALL be 1 for exactly one cycle with owner's latched addr/we/wdata; mem_we=0 for fetch.
REQ-012 WAIT SHALL last MEM_LAT cycles, counted by a latency counter of width clog2(MEM_LAT+1); on its last cycle, mem_rdata SHALL be captured into the owner's rdata register (reads only; writes leave d_rdata unchanged).
REQ-013 In RESP, the owner's ready SHALL pulse for exactly one cycle; the other ready SHALL stay 0; the FSM SHALL then return to IDLE.
REQ-014 Latency: request sampled in IDLE at edge N -> ready high during cycle N+2+MEM_LAT; max throughput one access per MEM_LAT+3 cycles.
REQ-015 Writes SHALL use the same timing as reads.
REQ-016 Requester dropping req mid-access: access SHALL complete and ready SHALL still pulse.
REQ-017 Requests arriving while busy SHALL be ignored until IDLE; requests held through RESP SHALL be arbitrated in the following IDLE cycle.
REQ-018 if_rdata/d_rdata SHALL hold their last value until overwritten.
REQ-019 if_ready and d_ready SHALL never be high simultaneously; mem_en SHALL never be high outside ISSUE.

Reset
REQ-020 rst SHALL immediately force state IDLE and drive mem_en, mem_we, if_ready, d_ready, busy to 0; mem_addr, mem_wdata, if_rdata, d_rdata, starve_cnt, and the latency counter to 0.
REQ-021 Reset mid-access SHALL abort it with no ready pulse; the first post-reset access SHALL behave as from cold.

Structure
REQ-022 FSM state encoding and the owner encoding (OWN_IF, OWN_D) SHALL live in the shared CPU package.
REQ-023 SHALL be a single module; the starvation counter MAY be split out as sub-module starve_counter.

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-024 Single fetch, if_req=1 at edge 0 with if_addr=5, memory returns 0xDEADBEEF -> mem_en at cycle 1 with mem_addr=5, if_ready pulse at cycle 4 with if_rdata=0xDEADBEEF.
REQ-025 Simultaneous if_req (addr 3) and d_req (read, addr 7) -> data served first (mem_addr=7); fetch issued in the following IDLE.
REQ-026 if_req held with d_req continuously high -> exactly 4 data grants, then fetch granted; starve_cnt back to 0.
REQ-027 Store with d_we=1, d_addr=9, d_wdata=0x1234 -> mem_en=mem_we=1 with mem_addr=9 and mem_wdata=0x1234, d_ready at cycle 4, d_rdata unchanged.
REQ-028 rst asserted during WAIT -> same-cycle mem_en=0, busy=0, no ready pulse; a fetch after reset completes with 4-cycle latency.
REQ-029 Continuous assertions across all tests: ready signals mutually exclusive; mem_en pulse width is 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Access sequencer: one access in flight, IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts data grants taken while a fetch is waiting; flags when fetch must be forced.
module starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic if_grant_i,
  input  logic d_grant_i,
  output logic starved_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Saturating count of data grants that bypassed a pending fetch.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_grant_i) begin
      cnt_d = '0;
    end else if (d_grant_i && (cnt_q != CntW'(STARVE_MAX))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == CntW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one fixed-latency memory port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_BITS-1:0] if_addr,
  output logic [XLEN-1:0]      if_rdata,
  output logic                 if_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 d_ready,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 busy
);

  localparam int unsigned LatW = $clog2(MEM_LAT + 1);

  arb_state_e           state_q, state_d;
  owner_e               owner_q, owner_d;
  logic                 we_q, we_d;
  logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]      if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]      d_rdata_q, d_rdata_d;
  logic                 if_ready_q, if_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic                 starved;
  logic                 if_grant, d_grant;

  // Data has priority unless the waiting fetch has been bypassed STARVE_MAX times.
  assign d_grant  = (state_q == StIdle) && d_req && !(if_req && starved);
  assign if_grant = (state_q == StIdle) && if_req && !d_grant;

  starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_counter (
    .clk       (clk),
    .rst       (rst),
    .if_req_i  (if_req),
    .if_grant_i(if_grant),
    .d_grant_i (d_grant),
    .starved_o (starved)
  );

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    lat_cnt_d   = lat_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_grant) begin
          owner_d     = OWN_D;
          we_d        = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          state_d     = StIssue;
        end else if (if_grant) begin
          owner_d    = OWN_IF;
          we_d       = 1'b0;
          mem_addr_d = if_addr;
          mem_en_d   = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        lat_cnt_d = LatW'(1);
        state_d   = StWait;
      end
      StWait: begin
        if (lat_cnt_q == LatW'(MEM_LAT)) begin
          lat_cnt_d = '0;
          state_d   = StResp;
          // Stores leave the load data register untouched.
          if (!we_q) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = mem_rdata;
            end
          end
          if_ready_d = (owner_q == OWN_IF);
          d_ready_d  = (owner_q == OWN_D);
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      lat_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ADDR_BITS  = 10;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 if_req;
  logic [ADDR_BITS-1:0] if_addr;
  logic [XLEN-1:0]      if_rdata;
  logic                 if_ready;
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [XLEN-1:0]      d_wdata;
  logic [XLEN-1:0]      d_rdata;
  logic                 d_ready;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic [XLEN-1:0]      mem_rdata;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] mem [0:(1<<ADDR_BITS)-1];

  mem_port_arbiter #(
    .XLEN      (XLEN),
    .ADDR_BITS (ADDR_BITS),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Read data follows the held address, so it is stable by the last WAIT cycle.
  assign mem_rdata = mem[mem_addr];

  // Continuous protocol checks, sampled on the falling edge.
  logic mem_en_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mem_en_prev = 1'b0;
    end else begin
      n_tests++;
      if (if_ready && d_ready) begin
        n_fail++;
        $display("FAIL ready_exclusive: if_ready=%b d_ready=%b, required not both 1",
                 if_ready, d_ready);
      end
      n_tests++;
      if (mem_en && mem_en_prev) begin
        n_fail++;
        $display("FAIL mem_en_width: mem_en high two cycles in a row, required 1-cycle pulse");
      end
      n_tests++;
      if (mem_en && !busy) begin
        n_fail++;
        $display("FAIL mem_en_idle: mem_en=1 with busy=0, required mem_en only in ISSUE");
      end
      mem_en_prev = mem_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({busy, mem_en, mem_we, if_ready, d_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/en/we/ifr/dr=%b, required 00000",
               {busy, mem_en, mem_we, if_ready, d_ready});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, required all 0",
               mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_fetch();
    if_addr = 10'd5;
    if_req  = 1'b1;
    tick();
    n_tests++;
    if ({busy, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 10'd5}) begin
      n_fail++;
      $display("FAIL fetch_issue: busy=%b en=%b we=%b addr=%0d, required 1 1 0 5",
               busy, mem_en, mem_we, mem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if ({mem_en, if_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL fetch_wait%0d: en=%b if_ready=%b, required 0 0", k, mem_en, if_ready);
      end
    end
    tick();
    n_tests++;
    if ({if_ready, d_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_ready: if_ready=%b d_ready=%b, required 1 0", if_ready, d_ready);
    end
    n_tests++;
    if (if_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fetch_data: if_rdata=%h, required deadbeef", if_rdata);
    end
    if_req = 1'b0;
    tick();
    n_tests++;
    if ({if_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_done: if_ready=%b busy=%b, required 0 0", if_ready, busy);
    end
    tick();
    n_tests++;
    if (if_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fetch_hold: if_rdata=%h, required deadbeef", if_rdata);
    end
  endtask

  task automatic test_arbitration();
    if_addr = 10'd3;
    if_req  = 1'b1;
    d_addr  = 10'd7;
    d_we    = 1'b0;
    d_req   = 1'b1;
    tick();
    n_tests++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd7}) begin
      n_fail++;
      $display("FAIL arb_data_first: en=%b we=%b addr=%0d, required 1 0 7",
               mem_en, mem_we, mem_addr);
    end
    repeat (3) tick();
    n_tests++;
    if ({d_ready, if_ready, d_rdata} !== {1'b1, 1'b0, 32'h77777777}) begin
      n_fail++;
      $display("FAIL arb_data_resp: d_ready=%b if_ready=%b d_rdata=%h, required 1 0 77777777",
               d_ready, if_ready, d_rdata);
    end
    d_req = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_idle: busy=%b, required 0", busy);
    end
    tick();
    n_tests++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd3}) begin
      n_fail++;
      $display("FAIL arb_fetch_next: en=%b we=%b addr=%0d, required 1 0 3",
               mem_en, mem_we, mem_addr);
    end
    repeat (3) tick();
    n_tests++;
    if ({if_ready, d_ready, if_rdata} !== {1'b1, 1'b0, 32'h33333333}) begin
      n_fail++;
      $display("FAIL arb_fetch_resp: if_ready=%b d_ready=%b if_rdata=%h, required 1 0 33333333",
               if_ready, d_ready, if_rdata);
    end
    if_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    int n_d     = 0;
    int last_t  = 0;
    int fetch_t = 0;
    bit fetched = 1'b0;
    bit seen    = 1'b0;
    if_addr = 10'd11;
    if_req  = 1'b1;
    d_addr  = 10'd20;
    d_we    = 1'b0;
    d_req   = 1'b1;
    for (int t = 1; t <= 40 && !fetched; t++) begin
      tick();
      if (mem_en) begin
        if (mem_addr == 10'd11) begin
          fetched = 1'b1;
          fetch_t = t;
        end else begin
          n_d++;
          if (n_d > 1) begin
            n_tests++;
            if (t - last_t != 5) begin
              n_fail++;
              $display("FAIL b2b_spacing: data grant gap=%0d cycles, required 5", t - last_t);
            end
          end
          last_t = t;
        end
      end
    end
    n_tests++;
    if (n_d != 4 || !fetched) begin
      n_fail++;
      $display("FAIL starve_grants: data grants=%0d fetched=%0d, required 4 1", n_d, fetched);
    end
    n_tests++;
    if (fetch_t != 21) begin
      n_fail++;
      $display("FAIL starve_fetch_cycle: fetch issued at cycle %0d, required 21", fetch_t);
    end
    n_tests++;
    if (dut.u_starve_counter.cnt_q !== 3'd0) begin
      n_fail++;
      $display("FAIL starve_clear: starve_cnt=%0d, required 0", dut.u_starve_counter.cnt_q);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (if_ready) seen = 1'b1;
    end
    n_tests++;
    if (!seen || if_rdata !== 32'hBBBB0011) begin
      n_fail++;
      $display("FAIL starve_fetch_data: seen=%0d if_rdata=%h, required 1 bbbb0011",
               seen, if_rdata);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (d_rdata !== 32'h20202020) begin
      n_fail++;
      $display("FAIL starve_data_val: d_rdata=%h, required 20202020", d_rdata);
    end
  endtask

  task automatic test_store();
    d_we    = 1'b1;
    d_addr  = 10'd9;
    d_wdata = 32'h1234;
    d_req   = 1'b1;
    tick();
    n_tests++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd9, 32'h1234}) begin
      n_fail++;
      $display("FAIL store_issue: en=%b we=%b addr=%0d wdata=%h, required 1 1 9 00001234",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    repeat (3) tick();
    n_tests++;
    if ({d_ready, if_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_ready: d_ready=%b if_ready=%b, required 1 0", d_ready, if_ready);
    end
    n_tests++;
    if (d_rdata !== 32'h20202020) begin
      n_fail++;
      $display("FAIL store_rdata_kept: d_rdata=%h, required 20202020", d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_access();
    int lat  = 0;
    bit seen = 1'b0;
    if_addr = 10'd5;
    if_req  = 1'b1;
    repeat (2) tick();
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({mem_en, busy, if_ready, d_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl: en/busy/ifr/dr=%b, required 0000",
               {mem_en, busy, if_ready, d_ready});
    end
    n_tests++;
    if ({if_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_data: if_rdata=%h d_rdata=%h, required 0 0", if_rdata, d_rdata);
    end
    if_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({if_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_no_pulse: if_ready=%b busy=%b, required 0 0", if_ready, busy);
    end
    if_req = 1'b1;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (if_ready) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    n_tests++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL rst_cold_latency: ready after %0d cycles, required 4", lat);
    end
    n_tests++;
    if (if_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rst_cold_data: if_rdata=%h, required deadbeef", if_rdata);
    end
    if_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 32'hA5000000 | i;
    mem[5]  = 32'hDEADBEEF;
    mem[3]  = 32'h33333333;
    mem[7]  = 32'h77777777;
    mem[11] = 32'hBBBB0011;
    mem[20] = 32'h20202020;

    test_reset();
    test_single_fetch();
    test_arbitration();
    test_starvation();
    test_store();
    test_reset_mid_access();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
